sb_dma_sequencer: RTL

//  Card-side DMA scheduler for the SB DSP mailbox path. Given a block length and a start

---
 rtl/sb_dma_sequencer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/sb_dma_sequencer.sv
// SB DSP mailbox DMA sequencer: paces one byte per dack, counts the block down, and raises irq at block end.
// Optional feature: define SB_DMA_AUTOINIT_EN to make a terminal byte reload the block instead of idling.
module sb_dma_sequencer #(
    parameter int CNT_W          = 16,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 4095,
    parameter int TO_W           = 12
) (
    input  logic             i_clk14,
    input  logic             i_chreset,
    input  logic             i_cden,
    input  logic             i_len_wr,
    input  logic [CNT_W-1:0] i_len_data,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_irq_ack,
    input  logic             i_dack_l,
    input  logic             i_tc_l,
    output logic             o_dreq,
    output logic             o_busy,
    output logic             o_irq_out,
    output logic             o_timeout_err,
    output logic [CNT_W-1:0] o_remaining
);

    localparam int              GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0]   GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_XFER = 3'd2,
        S_GAP  = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_dack_m;
    logic              r_dack_s;
    logic              r_dack_d;
    logic              r_tc_m;
    logic              r_tc_s;

    logic [CNT_W-1:0]  r_len;
    logic [CNT_W-1:0]  r_remaining;
    logic [TO_W-1:0]   r_to_cnt;
    logic [GW-1:0]     r_gap_cnt;
    logic              r_irq;
    logic              r_timeout_err;
    logic              r_tc_seen;

    logic              w_abort;
    logic              w_dack_fall;
    logic              w_start_blk;
    logic              w_rearm;
    logic              w_terminal;
    logic              w_reload;
    logic              w_dec_rem;
    logic              w_to_inc;
    logic              w_to_expire;
    logic              w_gap_inc;
    logic              w_set_tc;

    // dack_l/tc_l come from the MCA side with no relation to clk14
    always_ff @(posedge i_clk14 or posedge i_chreset) begin
        if (i_chreset) begin
            r_dack_m <= 1'b0;
            r_dack_s <= 1'b0;
            r_dack_d <= 1'b0;
            r_tc_m   <= 1'b0;
            r_tc_s   <= 1'b0;
        end else begin
            r_dack_m <= ~i_dack_l;
            r_dack_s <= r_dack_m;
            r_dack_d <= r_dack_s;
            r_tc_m   <= ~i_tc_l;
            r_tc_s   <= r_tc_m;
        end
    end

    assign w_dack_fall = r_dack_d & ~r_dack_s;
    assign w_abort     = i_stop | ~i_cden;

    always_ff @(posedge i_clk14 or posedge i_chreset) begin
        if (i_chreset) r_state <= S_IDLE;
        else           r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_blk = 1'b0;
        w_rearm     = 1'b0;
        w_terminal  = 1'b0;
        w_reload    = 1'b0;
        w_dec_rem   = 1'b0;
        w_to_inc    = 1'b0;
        w_to_expire = 1'b0;
        w_gap_inc   = 1'b0;
        w_set_tc    = 1'b0;
        if (w_abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        w_state_nxt = S_REQ;
                        w_start_blk = 1'b1;
                    end
                end
                S_REQ: begin
                    if (r_dack_s) begin
                        w_state_nxt = S_XFER;
                    end else if (r_to_cnt == TO_LAST) begin
                        w_state_nxt = S_ERR;
                        w_to_expire = 1'b1;
                    end else begin
                        w_to_inc = 1'b1;
                    end
                end
                S_XFER: begin
                    w_set_tc = r_tc_s & r_dack_s;
                    if (w_dack_fall) begin
                        if ((r_remaining == '0) || r_tc_seen) begin
                            w_terminal = 1'b1;
`ifdef SB_DMA_AUTOINIT_EN
                            w_reload    = 1'b1;
                            w_state_nxt = (GAP_CYCLES == 0) ? S_REQ : S_GAP;
`else
                            w_state_nxt = S_IDLE;
`endif
                        end else begin
                            w_dec_rem   = 1'b1;
                            w_state_nxt = (GAP_CYCLES == 0) ? S_REQ : S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) w_state_nxt = S_REQ;
                    else                       w_gap_inc   = 1'b1;
                end
                S_ERR: begin
                    if (i_start) begin
                        w_state_nxt = S_REQ;
                        w_rearm     = 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Both timers idle at zero outside their own state, so every REQ/GAP entry starts fresh
    always_ff @(posedge i_clk14 or posedge i_chreset) begin
        if (i_chreset) begin
            r_to_cnt  <= '0;
            r_gap_cnt <= '0;
        end else begin
            if (w_to_inc)              r_to_cnt <= r_to_cnt + 1'b1;
            else if (r_state != S_REQ) r_to_cnt <= '0;
            if (w_gap_inc)             r_gap_cnt <= r_gap_cnt + 1'b1;
            else if (r_state != S_GAP) r_gap_cnt <= '0;
        end
    end

    always_ff @(posedge i_clk14 or posedge i_chreset) begin
        if (i_chreset) begin
            r_len         <= '0;
            r_remaining   <= '0;
            r_irq         <= 1'b0;
            r_timeout_err <= 1'b0;
            r_tc_seen     <= 1'b0;
        end else begin
            if (i_len_wr) r_len <= i_len_data;

            // A start in the same cycle as len_wr launches with the previously loaded length
            if (w_start_blk || w_reload)           r_remaining <= r_len;
            else if (w_dec_rem)                    r_remaining <= r_remaining - 1'b1;
            else if (i_len_wr && r_state == S_IDLE) r_remaining <= i_len_data;

            if (w_terminal)     r_irq <= 1'b1;
            else if (i_irq_ack) r_irq <= 1'b0;

            if (w_to_expire)               r_timeout_err <= 1'b1;
            else if (w_start_blk || w_rearm) r_timeout_err <= 1'b0;

            if (w_start_blk || w_reload) r_tc_seen <= 1'b0;
            else if (w_set_tc)           r_tc_seen <= 1'b1;
        end
    end

    assign o_dreq        = (r_state == S_REQ);
    assign o_busy        = (r_state != S_IDLE);
    assign o_irq_out     = r_irq;
    assign o_timeout_err = r_timeout_err;
    assign o_remaining   = r_remaining;

endmodule
